prog_loader: RTL and testbench

Boot-time program loader for the RV32i core. Receives a framed byte stream, writes each assembled 32-bit little-endian word into program memory through a single write port, and holds the core in reset until the whole frame has been written and its checksum verified. It is the hardware writer whose reader is the core's instruction fetch, replacing simulation-only memory preloading on silicon.

---
 rtl/prog_loader.sv | 117 +++++++++++
 tb/tb_prog_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: assembles a framed little-endian byte stream into 32-bit program-memory writes
// and holds the core in reset until the whole frame is written and its XOR checksum matches.
module prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    input  logic              start_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_rst_n_o,
    output logic              done_o,
    output logic              error_o
);
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    state_t              state_q;
    logic [15:0]         cnt_q, idx_q, cnt_d;
    logic [1:0]          lane_q;
    logic [7:0]          csum_q;
    logic [23:0]         shift_q;
    logic                ready_q, we_q, core_q, done_q, err_q, xfer;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    assign xfer  = in_valid_i && ready_q;
    assign cnt_d = {in_data_i, cnt_q[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CNT_LO;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            csum_q  <= '0;
            shift_q <= '0;
            ready_q <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            core_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_CNT_LO: if (xfer) begin
                    cnt_q[7:0] <= in_data_i;
                    state_q    <= S_CNT_HI;
                end
                S_CNT_HI: if (xfer) begin
                    cnt_q[15:8] <= in_data_i;
                    idx_q       <= '0;
                    lane_q      <= '0;
                    csum_q      <= '0;
                    if (32'(cnt_d) > DEPTH) begin
                        state_q <= S_ERR;
                        ready_q <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= (cnt_d == 16'd0) ? S_CSUM : S_DATA;
                    end
                end
                S_DATA: if (xfer) begin
                    csum_q  <= csum_q ^ in_data_i;
                    lane_q  <= lane_q + 2'd1;
                    shift_q <= {in_data_i, shift_q[23:8]};
                    // The fourth byte completes the word; earlier bytes sit in shift_q, oldest lowest.
                    if (lane_q == 2'd3) begin
                        we_q    <= 1'b1;
                        addr_q  <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
                        wdata_q <= {in_data_i, shift_q};
                        idx_q   <= idx_q + 16'd1;
                        if (idx_q == cnt_q - 16'd1) state_q <= S_CSUM;
                    end
                end
                S_CSUM: if (xfer) begin
                    ready_q <= 1'b0;
                    if (in_data_i == csum_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        core_q  <= 1'b1;
                    end else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end
                end
                S_DONE, S_ERR: if (start_i) begin
                    state_q <= S_CNT_LO;
                    ready_q <= 1'b1;
                    core_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    idx_q   <= '0;
                    lane_q  <= '0;
                    csum_q  <= '0;
                end
                default: state_q <= S_CNT_LO;
            endcase
        end
    end

    assign in_ready_o   = ready_q;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign core_rst_n_o = core_q;
    assign done_o       = done_q;
    assign error_o      = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: random and directed frames into two loaders (base 0 and base 0xFE),
// with expected writes queued by the driver and checked by a separate write monitor.
module tb_prog_loader;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic rdy0, we0, crst0, done0, err0, rdy1, we1, crst1, done1, err1;
    logic [7:0] addr0, addr1;
    logic [31:0] wd0, wd1;
    int cyc = 0, checks = 0, errors = 0;

    typedef struct {int idx; logic [31:0] data; int cyc;} wr_t;
    wr_t q0[$], q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(rdy0),
        .start_i(start), .mem_we_o(we0), .mem_addr_o(addr0), .mem_wdata_o(wd0),
        .core_rst_n_o(crst0), .done_o(done0), .error_o(err0));
    prog_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(rdy1),
        .start_i(start), .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wd1),
        .core_rst_n_o(crst1), .done_o(done1), .error_o(err1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (we0) begin
            if (q0.size() == 0) chk("dut0 unexpected write", 32'(we0), 0);
            else begin
                wr_t e;
                e = q0.pop_front();
                chk("dut0 addr", 32'(addr0), 32'(e.idx % 256));
                chk("dut0 wdata", wd0, e.data);
                chk("dut0 write cycle", cyc, e.cyc);
            end
        end
        if (we1) begin
            if (q1.size() == 0) chk("dut1 unexpected write", 32'(we1), 0);
            else begin
                wr_t e;
                e = q1.pop_front();
                chk("dut1 addr", 32'(addr1), 32'((254 + e.idx) % 256));
                chk("dut1 wdata", wd1, e.data);
                chk("dut1 write cycle", cyc, e.cyc);
            end
        end
    end

    task automatic check_state(input string t, input logic d, input logic e, input logic c, input logic r);
        chk({t, " done0"}, 32'(done0), 32'(d));
        chk({t, " error0"}, 32'(err0), 32'(e));
        chk({t, " core_rst_n0"}, 32'(crst0), 32'(c));
        chk({t, " in_ready0"}, 32'(rdy0), 32'(r));
        chk({t, " done1"}, 32'(done1), 32'(d));
        chk({t, " error1"}, 32'(err1), 32'(e));
        chk({t, " core_rst_n1"}, 32'(crst1), 32'(c));
        chk({t, " in_ready1"}, 32'(rdy1), 32'(r));
    endtask

    task automatic check_reset(input string t);
        check_state(t, 0, 0, 0, 1);
        chk({t, " mem_we"}, 32'({we0, we1}), 0);
        chk({t, " mem_addr"}, 32'({addr0, addr1}), 0);
        chk({t, " mem_wdata0"}, wd0, 0);
        chk({t, " mem_wdata1"}, wd1, 0);
    endtask

    // Drives one byte for exactly one cycle; start pulses here land in loading states and must be ignored.
    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        start    = ($urandom_range(0, 7) == 0);
        chk("in_ready while loading", 32'({rdy0, rdy1}), 32'b11);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) begin
            start   = ($urandom_range(0, 7) == 0);
            in_data = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic restart();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check_state("after start", 0, 0, 0, 1);
    endtask

    // csum_mode: -1 correct checksum, -2 random wrong checksum, otherwise the literal byte sent.
    task automatic send_frame(input logic [31:0] w[$], input int gap, input int csum_mode, input int abort_at);
        logic [15:0] n;
        logic [7:0] x, cs, b;
        logic [31:0] wd;
        int sent;
        wr_t e;
        n = 16'(w.size());
        x = 8'h00;
        sent = 0;
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
        for (int i = 0; i < w.size(); i++) begin
            wd = w[i];
            for (int j = 0; j < 4; j++) begin
                if (sent == abort_at) begin
                    #2 rst_n = 1'b0;
                    #1 check_reset("async abort");
                    #1 rst_n = 1'b1;
                    @(negedge clk);
                    chk("writes pending after abort", q0.size() + q1.size(), 0);
                    return;
                end
                b = wd[8*j +: 8];
                x ^= b;
                if (j == 3) begin
                    e.idx = i;
                    e.data = wd;
                    e.cyc = cyc + 1;
                    q0.push_back(e);
                    q1.push_back(e);
                end
                send_byte(b, gap);
                sent++;
            end
        end
        cs = (csum_mode == -1) ? x : (csum_mode == -2) ? (x ^ 8'($urandom_range(1, 255))) : 8'(csum_mode);
        send_byte(cs, 0);
        if (cs == x) check_state("good frame", 1, 0, 1, 0);
        else check_state("bad checksum", 0, 1, 0, 0);
        chk("writes pending after frame", q0.size() + q1.size(), 0);
    endtask

    initial begin
        logic [31:0] good[$], none[$], r[$];
        good = '{32'h0000_0013, 32'h0040_006F};
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("after release");

        send_frame(good, 0, -1, -1);
        restart();
        send_frame(good, 3, -1, -1);
        restart();
        send_frame(good, 0, 8'h00, -1);
        repeat (3) @(negedge clk);
        check_state("error holds", 0, 1, 0, 0);
        restart();
        send_frame(good, 0, -1, -1);
        restart();
        send_frame(none, 0, 8'h00, -1);
        restart();
        r = '{32'($urandom), 32'($urandom), 32'($urandom)};
        send_frame(r, 1, -1, -1);
        restart();

        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check_state("oversize count", 0, 1, 0, 0);
        repeat (2) @(negedge clk);
        chk("oversize writes", q0.size() + q1.size(), 0);
        restart();

        send_frame(good, 0, -1, 6);
        send_frame(good, 0, -1, -1);
        restart();

        r.delete();
        for (int i = 0; i < 256; i++) r.push_back(32'($urandom));
        send_frame(r, 0, -1, -1);
        restart();

        repeat (25) begin
            r.delete();
            repeat ($urandom_range(0, 6)) r.push_back(32'($urandom));
            send_frame(r, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? -2 : -1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            restart();
        end

        repeat (3) @(negedge clk);
        chk("final pending writes", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
